ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side streaming engine for a single-port-write / combinational-read RAM block. On a start command it walks `length` consecutive addresses from `base_addr`, wrapping modulo RAM size, and presents each word on a registered valid/ready stream with a last marker. It drives the RAM's read address and consumes its combinational read data. It is the consumer counterpart to whatever logic fills the RAM through the write port.

## Interface
- `RAM_WIDTH`, 8: data word width; must match the attached RAM.
- `RAM_ADDR_BITS`, 8: address width; RAM_SIZE = 2**RAM_ADDR_BITS.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  burst request; sampled only in IDLE.
- `base_addr`  in  RAM_ADDR_BITS  first read address; captured with `start`.
- `length`  in  RAM_ADDR_BITS+1  word count; captured with `start`; 0 is legal.
- `abort`  in  1  cancels the current burst; has priority over all other inputs.
- `ra`  out  RAM_ADDR_BITS  read address to the RAM.
- `rd_data`  in  RAM_WIDTH  combinational RAM read data for `ra`.
- `m_data`  out  RAM_WIDTH  stream data (registered).
- `m_valid`  out  1  stream data valid.
- `m_last`  out  1  marks the final word of a burst; qualified by `m_valid`.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high in STREAM and DONE.
- `done`  out  1  one-cycle pulse at normal burst completion.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE with `start`=1 and `length`>0: capture `addr`=`base_addr` and `rem`=`length`, then go to STREAM.
- IDLE with `start`=1 and `length`=0: go to DONE. No word is emitted.
- STREAM load condition: `rem`>0 and (`m_valid`=0 or `m_ready`=1).
- On load:
  - `m_data`<=`rd_data`, `m_valid`<=1, `m_last`<=(`rem`==1).
  - `addr`<=`addr`+1 mod RAM_SIZE; `rem`<=`rem`-1.
- STREAM with `rem`=0: on the handshake (`m_valid`&`m_ready`) of the last word, clear `m_valid`/`m_last` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `ra`=`addr` at all times (registered).
- Backpressure: while `m_valid`=1 and `m_ready`=0, `m_data`, `m_last`, `ra` and `rem` hold.
- `abort`=1 in any state: next edge goes to IDLE with `m_valid`=0, `m_last`=0 and no `done` pulse. If `abort` and `start` are both high in IDLE, `abort` wins.
- `start` in STREAM or DONE is ignored.
- `length` > RAM_SIZE is legal; addresses wrap and words repeat.
- Arithmetic:
  - `rem` is RAM_ADDR_BITS+1 bits and never underflows.
  - `addr` increment truncates to RAM_ADDR_BITS.
- RAM coherency: a word reflects memory contents before any write committed on the same edge as its load.

## Timing
- Reset values: state=IDLE, `ra`=0, `m_data`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0.
- Latency: `start` sampled at edge k gives `busy`=1 after k; the first `m_valid`=1 appears after edge k+1.
- Throughput: 1 word/cycle while `m_ready`=1.
- A burst of N words with continuous `m_ready` finishes its last handshake at edge k+N+1. `done` is high during the following cycle, and IDLE is reached one edge later.
- Length 0: `done` is high in the cycle after edge k.
- Reset mid-burst: immediate return to reset values. The stream drops with no last marker.

## Structure
- Shared package `ram_reader_pkg`: state encoding (IDLE=2'd0, STREAM=2'd1, DONE=2'd2) and a helper constant for the counter width (RAM_ADDR_BITS+1).
- No sub-module. The output register is inline.
- The testbench instantiates the existing RAM block alongside this block: `ra`/`rd_data` are wired directly, and the write port is driven by the bench.

## Test plan
Parameters for all scenarios: RAM_WIDTH=8, RAM_ADDR_BITS=4.
- Basic burst: preload mem[i]=i+8'h10; start with base=3, length=4, `m_ready`=1. Required: 8'h13, 8'h14, 8'h15, 8'h16 on consecutive cycles; `m_last` only on 8'h16; `done` one cycle later.
- Wrap: base=14, length=4. Required: data from addresses 14, 15, 0, 1; `ra` sequence 14, 15, 0, 1, 2.
- Backpressure: length=3; hold `m_ready`=0 for 3 cycles after the first valid. Required: `m_data`, `ra` and `m_last` stable; all 3 words delivered in order; no loss or duplication.
- Zero length: start with length=0. Required: no `m_valid`; `done`=1 exactly one cycle after the start edge.
- Abort and reset: abort during word 2 of length=8. Required: `m_valid`=0 next cycle, no `done`, `start` accepted again afterwards. Then assert `rst_n`=0 mid-burst. Required: all outputs at reset values without waiting for a clock.
- Start ignored and write coherency:
  - `start` pulses while busy do not affect the running burst.
  - A bench write to the next read address at the load edge yields the old value.

Source files
------------

// File: rtl/ram_reader_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ram_reader_pkg
// Brief  : Shared definitions for the RAM stream reader: FSM state
//          encoding and the helper that sizes the remaining-word counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package ram_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } reader_state_t;

   // The counter needs one bit beyond the address so that a full-RAM burst
   // (length == RAM_SIZE) and longer wrapping bursts are representable.
   function automatic int rem_width(input int addr_bits);
      return addr_bits + 1;
   endfunction

endpackage : ram_reader_pkg
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ram_stream_reader
// Brief  : Walks a burst of consecutive RAM addresses (wrapping modulo the
//          RAM size) and presents each word on a registered valid/ready
//          stream with a last marker.
// Rev    : 1.0  initial release
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   burst request, sampled only when idle
//   base_addr  in   first read address, captured with start
//   length     in   word count (RAM_ADDR_BITS+1 bits), 0 is legal
//   abort      in   cancels the current burst, highest priority
//   ra         out  registered read address to the RAM
//   rd_data    in   combinational RAM read data for ra
//   m_data     out  registered stream data
//   m_valid    out  stream data valid
//   m_last     out  final word of the burst (qualified by m_valid)
//   m_ready    in   downstream accept
//   busy       out  high while streaming or completing
//   done       out  one-cycle pulse at normal completion
//------------------------------------------------------------------------------
module ram_stream_reader
   import ram_reader_pkg::*;
#(
   parameter int RAM_WIDTH     = 8,
   parameter int RAM_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [RAM_ADDR_BITS-1:0] base_addr,
   input  logic [RAM_ADDR_BITS:0]   length,
   input  logic                     abort,
   output logic [RAM_ADDR_BITS-1:0] ra,
   input  logic [RAM_WIDTH-1:0]     rd_data,
   output logic [RAM_WIDTH-1:0]     m_data,
   output logic                     m_valid,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic                     busy,
   output logic                     done
);

   localparam int REM_W = rem_width(RAM_ADDR_BITS);

   localparam logic [REM_W-1:0]         c_REM_ONE  = {{(REM_W-1){1'b0}}, 1'b1};
   localparam logic [RAM_ADDR_BITS-1:0] c_ADDR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

   reader_state_t            r_state;
   reader_state_t            w_state_nxt;

   logic [RAM_ADDR_BITS-1:0] r_addr;
   logic [REM_W-1:0]         r_rem;
   logic [RAM_WIDTH-1:0]     r_m_data;
   logic                     r_m_valid;
   logic                     r_m_last;

   logic                     w_hs;
   logic                     w_load;
   logic                     w_capture;
   logic                     w_drain;

   //---------------------------------------------------------------------------
   // Next-state and datapath control
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_hs        = r_m_valid & m_ready;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_drain     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            // The output register refills whenever it is empty or being
            // emptied this cycle, giving one word per cycle under m_ready.
            w_load = (r_rem != '0) && (!r_m_valid || m_ready);
            // Once every word is loaded, completion waits for the final
            // word to be accepted downstream.
            if ((r_rem == '0) && w_hs) begin
               w_drain     = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Abort overrides every other request, including a start in idle.
      if (abort) begin
         w_state_nxt = ST_IDLE;
         w_load      = 1'b0;
         w_capture   = 1'b0;
         w_drain     = 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Address / counter / output register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_rem     <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (abort) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
         r_rem     <= '0;
      end else if (w_capture) begin
         r_addr <= base_addr;
         r_rem  <= length;
      end else if (w_load) begin
         // rd_data is sampled at this edge, so a RAM write committing on
         // the same edge is not visible in this word.
         r_m_data  <= rd_data;
         r_m_valid <= 1'b1;
         r_m_last  <= (r_rem == c_REM_ONE);
         r_addr    <= r_addr + c_ADDR_ONE;
         r_rem     <= r_rem - c_REM_ONE;
      end else if (w_drain) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign ra      = r_addr;
   assign m_data  = r_m_data;
   assign m_valid = r_m_valid;
   assign m_last  = r_m_last;
   assign busy    = (r_state == ST_STREAM) || (r_state == ST_DONE);
   assign done    = (r_state == ST_DONE);

endmodule : ram_stream_reader
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_ram_stream_reader
// Brief  : Directed self-checking bench for ram_stream_reader with a small
//          combinational-read RAM model whose write port the bench drives.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_ram_stream_reader;

   localparam int W  = 8;
   localparam int AB = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AB-1:0] base_addr;
   logic [AB:0]   length;
   logic          abort;
   logic [AB-1:0] ra;
   logic [W-1:0]  rd_data;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;
   logic          busy;
   logic          done;

   // RAM model: synchronous write, combinational read
   logic          we;
   logic [AB-1:0] wa;
   logic [W-1:0]  wd;
   logic [W-1:0]  mem [0:(1<<AB)-1];

   always @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end
   assign rd_data = mem[ra];

   int checks   = 0;
   int failures = 0;

   ram_stream_reader #(
      .RAM_WIDTH     (W),
      .RAM_ADDR_BITS (AB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .ra        (ra),
      .rd_data   (rd_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: inputs were driven at a falling edge, outputs are sampled
   // at the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_word(input string tag, input logic [7:0] d, input logic l);
      check({tag, ".valid"}, {31'd0, m_valid}, 32'd1);
      check({tag, ".data"},  {24'd0, m_data},  {24'd0, d});
      check({tag, ".last"},  {31'd0, m_last},  {31'd0, l});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
      abort = 1'b0; m_ready = 1'b0; we = 1'b0; wa = '0; wd = '0;

      // ---------------- reset values ----------------
      #3;
      check("rst.ra",    {28'd0, ra},      32'd0);
      check("rst.data",  {24'd0, m_data},  32'd0);
      check("rst.valid", {31'd0, m_valid}, 32'd0);
      check("rst.last",  {31'd0, m_last},  32'd0);
      check("rst.busy",  {31'd0, busy},    32'd0);
      check("rst.done",  {31'd0, done},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- preload mem[i] = i + 0x10 ----------------
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; wa = i[AB-1:0]; wd = 8'(i + 16);
         step();
      end
      we = 1'b0;

      // ---------------- basic burst: base 3, length 4 ----------------
      m_ready = 1'b1; start = 1'b1; base_addr = 4'd3; length = 5'd4;
      step();
      start = 1'b0;
      check("basic.busy",   {31'd0, busy},    32'd1);
      check("basic.nv",     {31'd0, m_valid}, 32'd0);
      check("basic.ra0",    {28'd0, ra},      32'd3);
      step(); check_word("basic.w0", 8'h13, 1'b0);
      step(); check_word("basic.w1", 8'h14, 1'b0);
      step(); check_word("basic.w2", 8'h15, 1'b0);
      step(); check_word("basic.w3", 8'h16, 1'b1);
      step();
      check("basic.done",   {31'd0, done},    32'd1);
      check("basic.vdone",  {31'd0, m_valid}, 32'd0);
      check("basic.bdone",  {31'd0, busy},    32'd1);
      step();
      check("basic.done2",  {31'd0, done},    32'd0);
      check("basic.idle",   {31'd0, busy},    32'd0);

      // ---------------- wrap: base 14, length 4 ----------------
      start = 1'b1; base_addr = 4'd14; length = 5'd4;
      step();
      start = 1'b0;
      check("wrap.ra0", {28'd0, ra}, 32'd14);
      step(); check_word("wrap.w0", 8'h1E, 1'b0); check("wrap.ra1", {28'd0, ra}, 32'd15);
      step(); check_word("wrap.w1", 8'h1F, 1'b0); check("wrap.ra2", {28'd0, ra}, 32'd0);
      step(); check_word("wrap.w2", 8'h10, 1'b0); check("wrap.ra3", {28'd0, ra}, 32'd1);
      step(); check_word("wrap.w3", 8'h11, 1'b1); check("wrap.ra4", {28'd0, ra}, 32'd2);
      step(); check("wrap.done", {31'd0, done}, 32'd1);
      step();

      // ---------------- backpressure: base 5, length 3 ----------------
      start = 1'b1; base_addr = 4'd5; length = 5'd3;
      step();
      start = 1'b0;
      step(); check_word("bp.w0", 8'h15, 1'b0); check("bp.ra", {28'd0, ra}, 32'd6);
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_word("bp.hold", 8'h15, 1'b0);
         check("bp.holdra", {28'd0, ra}, 32'd6);
      end
      m_ready = 1'b1;
      step(); check_word("bp.w1", 8'h16, 1'b0); check("bp.ra1", {28'd0, ra}, 32'd7);
      step(); check_word("bp.w2", 8'h17, 1'b1);
      step();
      check("bp.done",  {31'd0, done},    32'd1);
      check("bp.nv",    {31'd0, m_valid}, 32'd0);
      step();

      // ---------------- zero length ----------------
      start = 1'b1; base_addr = 4'd7; length = 5'd0;
      step();
      start = 1'b0;
      check("zero.done",  {31'd0, done},    32'd1);
      check("zero.nv",    {31'd0, m_valid}, 32'd0);
      check("zero.busy",  {31'd0, busy},    32'd1);
      step();
      check("zero.done2", {31'd0, done},    32'd0);
      check("zero.nv2",   {31'd0, m_valid}, 32'd0);
      check("zero.idle",  {31'd0, busy},    32'd0);

      // ---------------- abort during word 2 of length 8 ----------------
      start = 1'b1; base_addr = 4'd0; length = 5'd8;
      step();
      start = 1'b0;
      step(); check_word("abort.w0", 8'h10, 1'b0);
      step(); check_word("abort.w1", 8'h11, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort.nv",   {31'd0, m_valid}, 32'd0);
      check("abort.nl",   {31'd0, m_last},  32'd0);
      check("abort.nd",   {31'd0, done},    32'd0);
      check("abort.idle", {31'd0, busy},    32'd0);
      step();
      check("abort.nd2",  {31'd0, done},    32'd0);
      // abort beats start in idle
      start = 1'b1; abort = 1'b1; base_addr = 4'd2; length = 5'd8;
      step();
      abort = 1'b0;
      check("abort.win",  {31'd0, busy},    32'd0);
      // restart accepted
      step();
      start = 1'b0;
      check("restart.busy", {31'd0, busy}, 32'd1);
      step(); check_word("restart.w0", 8'h12, 1'b0);
      step(); check_word("restart.w1", 8'h13, 1'b0);

      // ---------------- asynchronous reset mid-burst ----------------
      #2 rst_n = 1'b0;
      #1;
      check("arst.ra",    {28'd0, ra},      32'd0);
      check("arst.data",  {24'd0, m_data},  32'd0);
      check("arst.valid", {31'd0, m_valid}, 32'd0);
      check("arst.last",  {31'd0, m_last},  32'd0);
      check("arst.busy",  {31'd0, busy},    32'd0);
      check("arst.done",  {31'd0, done},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ---------------- start ignored + write coherency ----------------
      start = 1'b1; base_addr = 4'd8; length = 5'd3;
      step();
      check("coh.ra0", {28'd0, ra}, 32'd8);
      // write the address being loaded on the next edge, and re-request
      // a different burst while busy
      we = 1'b1; wa = 4'd8; wd = 8'hAA;
      start = 1'b1; base_addr = 4'd0; length = 5'd5;
      step();
      we = 1'b0;
      check_word("coh.w0", 8'h18, 1'b0);
      check("coh.ra1", {28'd0, ra}, 32'd9);
      step();
      start = 1'b0;
      check_word("coh.w1", 8'h19, 1'b0);
      step(); check_word("coh.w2", 8'h1A, 1'b1);
      step(); check("coh.done", {31'd0, done}, 32'd1);
      step(); check("coh.idle", {31'd0, busy}, 32'd0);
      // the write did land in the RAM
      start = 1'b1; base_addr = 4'd8; length = 5'd1;
      step();
      start = 1'b0;
      step(); check_word("coh.new", 8'hAA, 1'b1);
      step(); check("coh.done2", {31'd0, done}, 32'd1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ram_stream_reader
`default_nettype wire
